// File: rtl/tg_inject_arbiter.sv
// Shares one router local injection port between N traffic generators (round-robin, packet-locked).
// Latency: request to grant 1 cycle; owner flit to o_flit 1 cycle (registered).
// Backpressure: i_port_ready gates new grants only in IDLE; losing requests simply stay pending.
module tg_inject_arbiter #(
    parameter int          N         = 4,
    parameter int          FLIT_W    = 32,
    parameter int          TYPE_LSB  = 28,
    parameter logic [1:0]  TAIL_CODE = 2'b11,
    parameter int          TIMEOUT   = 16,
    parameter int          CNT_W     = 16,
    localparam int         OW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_enable,
    input  logic [N-1:0]          i_req,
    output logic [N-1:0]          o_grant,
    input  logic [N*FLIT_W-1:0]   i_flit,
    input  logic                  i_port_ready,
    output logic [FLIT_W-1:0]     o_flit,
    output logic [OW-1:0]         o_owner,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_err,
    output logic [CNT_W-1:0]      o_pkt_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q,   ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [FLIT_W-1:0] flit_q,  flit_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              tail_q,  tail_d;

    logic [FLIT_W-1:0] lane [N];
    logic [FLIT_W-1:0] own_flit;
    logic              own_vld;
    logic              own_tail;
    logic              win_vld;
    logic [OW-1:0]     win_idx;
    logic              timeout_c;
    logic              err_c;

    // Split the flat flit bus into per-generator lanes
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lane[g] = i_flit[g*FLIT_W +: FLIT_W];
    end

    // Only the current owner's lane is ever looked at
    assign own_flit = lane[owner_q];
    assign own_vld  = own_flit[FLIT_W-1];
    assign own_tail = own_vld && (own_flit[TYPE_LSB +: 2] == TAIL_CODE);

    // Round-robin pick: first requester at or above the pointer, wrapping to 0.
    // Scanning from the far end down lets the nearest hit overwrite earlier ones.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (i_req[idx]) begin
                win_vld = 1'b1;
                win_idx = OW'(idx);
            end
        end
    end

    // Packet-lock FSM: grant, wait for head, stream to tail, release
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        flit_d    = '0;
        cnt_d     = cnt_q;
        tail_d    = tail_q;
        timeout_c = 1'b0;
        err_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_enable && i_port_ready && win_vld) begin
                    owner_d = win_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                timer_d = '0;
                tail_d  = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (own_vld) begin
                    flit_d = own_flit;
                    if (own_tail) begin
                        tail_d  = 1'b1;
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else if (timer_q >= TW'(TIMEOUT)) begin
                    timeout_c = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STREAM: begin
                flit_d = own_flit;
                if (!own_vld) begin
                    err_c   = 1'b1;
                    state_d = S_RELEASE;
                end else if (own_tail) begin
                    tail_d  = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
                if (tail_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
                owner_d = '0;
                tail_d  = 1'b0;
                timer_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = '0;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            flit_q  <= '0;
            cnt_q   <= '0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            flit_q  <= flit_d;
            cnt_q   <= cnt_d;
            tail_q  <= tail_d;
        end
    end

    assign o_grant   = (state_q == S_GRANT) ? ({{(N-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign o_busy    = (state_q != S_IDLE);
    assign o_owner   = owner_q;
    assign o_flit    = flit_q;
    assign o_pkt_cnt = cnt_q;
    assign o_timeout = timeout_c;
    assign o_err     = err_c;

endmodule

// File: tb/tb_tg_inject_arbiter.sv
// Directed bench for tg_inject_arbiter: vector table for one packet, then hand sequences.
// Inputs driven on the falling edge, outputs checked 1 ns later.
// Non-owner lanes carry valid tail flits so any leak through the mux shows up.
module tb_tg_inject_arbiter;

    logic         clk;
    logic         reset_n;
    logic         i_enable;
    logic [3:0]   i_req;
    logic [3:0]   o_grant;
    logic [127:0] i_flit;
    logic         i_port_ready;
    logic [31:0]  o_flit;
    logic [1:0]   o_owner;
    logic         o_busy;
    logic         o_timeout;
    logic         o_err;
    logic [15:0]  o_pkt_cnt;

    logic [31:0]  lane [4];

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    assign i_flit = {lane[3], lane[2], lane[1], lane[0]};

    tg_inject_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_enable     (i_enable),
        .i_req        (i_req),
        .o_grant      (o_grant),
        .i_flit       (i_flit),
        .i_port_ready (i_port_ready),
        .o_flit       (o_flit),
        .o_owner      (o_owner),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout),
        .o_err        (o_err),
        .o_pkt_cnt    (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] f2;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic [1:0]  e_owner;
        logic [31:0] e_flit;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_busy",  32'(o_busy), 32'h0);
        chk("rst_owner", 32'(o_owner), 32'h0);
        chk("rst_flit",  o_flit, 32'h0);
        chk("rst_tmo",   32'(o_timeout), 32'h0);
        chk("rst_err",   32'(o_err), 32'h0);
        chk("rst_cnt",   32'(o_pkt_cnt), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_req   = 4'b0000;
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = 0;
    endtask

    // Present req (with enable/ready high) until a grant shows; check it is one-hot for w
    task automatic wait_grant(input logic [3:0] req, input int w, output bit got, output int waited);
        got    = 1'b0;
        waited = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            i_req        = req;
            i_enable     = 1'b1;
            i_port_ready = 1'b1;
            for (int j = 0; j < 4; j++) lane[j] = (j == w) ? 32'h0 : 32'hFFFF_FFFF;
            #1;
            if (c == 0) chk("cnt_idle", 32'(o_pkt_cnt), 32'(exp_cnt));
            if (o_grant != 4'b0000) begin
                got    = 1'b1;
                waited = c;
                chk("grant", 32'(o_grant), 32'(4'b0001 << w));
                chk("owner", 32'(o_owner), 32'(w));
            end
        end
        if (!got) chk("grant_wait", 32'(o_grant), 32'(4'b0001 << w));
    endtask

    // One packet of n flits from requester w; tail on the last flit or a valid drop after it.
    // Returns after the RELEASE cycle has been checked.
    task automatic do_pkt(input logic [3:0] req, input int w, input int n, input bit tail,
                          output int waited);
        logic [31:0] f [8];
        logic [31:0] prev;
        bit          got;
        for (int k = 0; k < n; k++) begin
            f[k] = 32'h8000_0000 | (((tail != 0) && (k == n - 1)) ? 32'h3000_0000 : 32'h1000_0000)
                   | (32'(w) << 8) | 32'(k);
        end
        wait_grant(req, w, got, waited);
        if (!got) return;
        prev = 32'h0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            lane[w] = f[k];
            #1;
            chk("no_overlap", 32'(o_grant), 32'h0);
            chk("busy",       32'(o_busy), 32'h1);
            chk("fwd",        o_flit, prev);
            chk("no_err",     32'(o_err), 32'h0);
            prev = f[k];
        end
        @(negedge clk);
        lane[w] = 32'h0;
        #1;
        chk("last_fwd", o_flit, prev);
        chk("err",      32'(o_err), tail ? 32'h0 : 32'h1);
        chk("busy_end", 32'(o_busy), 32'h1);
        if (tail) begin
            exp_cnt++;
        end else begin
            @(negedge clk);
            #1;
            chk("rel_flit", o_flit, 32'h0);
            chk("rel_err",  32'(o_err), 32'h0);
            chk("rel_busy", 32'(o_busy), 32'h1);
        end
    endtask

    initial begin
        bit got;
        int waited;

        tbl[0] = '{4'b0100, 32'h0,         4'b0000, 1'b0, 2'd0, 32'h0,         16'd0};
        tbl[1] = '{4'b0100, 32'h0,         4'b0100, 1'b1, 2'd2, 32'h0,         16'd0};
        tbl[2] = '{4'b0000, 32'h8000_0001, 4'b0000, 1'b1, 2'd2, 32'h0,         16'd0};
        tbl[3] = '{4'b0000, 32'h9000_0002, 4'b0000, 1'b1, 2'd2, 32'h8000_0001, 16'd0};
        tbl[4] = '{4'b0000, 32'h9000_0002, 4'b0000, 1'b1, 2'd2, 32'h9000_0002, 16'd0};
        tbl[5] = '{4'b0000, 32'hB000_0003, 4'b0000, 1'b1, 2'd2, 32'h9000_0002, 16'd0};
        tbl[6] = '{4'b0000, 32'h0,         4'b0000, 1'b1, 2'd2, 32'hB000_0003, 16'd0};
        tbl[7] = '{4'b0000, 32'h0,         4'b0000, 1'b0, 2'd0, 32'h0,         16'd1};

        clk          = 1'b0;
        reset_n      = 1'b0;
        i_enable     = 1'b1;
        i_port_ready = 1'b1;
        i_req        = 4'b0000;
        for (int j = 0; j < 4; j++) lane[j] = 32'h0;
        #3;
        chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;

        // Single requester 2, H B B T, owner drops its request after the grant
        lane[1] = 32'hFFFF_FFFF;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            i_req   = tbl[r].req;
            lane[2] = tbl[r].f2;
            #1;
            chk($sformatf("v%0d_grant", r), 32'(o_grant), 32'(tbl[r].e_grant));
            chk($sformatf("v%0d_busy", r),  32'(o_busy), 32'(tbl[r].e_busy));
            chk($sformatf("v%0d_owner", r), 32'(o_owner), 32'(tbl[r].e_owner));
            chk($sformatf("v%0d_flit", r),  o_flit, tbl[r].e_flit);
            chk($sformatf("v%0d_cnt", r),   32'(o_pkt_cnt), 32'(tbl[r].e_cnt));
            chk($sformatf("v%0d_tmo", r),   32'(o_timeout), 32'h0);
            chk($sformatf("v%0d_err", r),   32'(o_err), 32'h0);
        end
        lane[1] = 32'h0;

        // Fair rotation with everyone requesting
        do_reset();
        do_pkt(4'b1111, 0, 4, 1'b1, waited);
        do_pkt(4'b1111, 1, 4, 1'b1, waited);
        do_pkt(4'b1111, 2, 4, 1'b1, waited);
        do_pkt(4'b1111, 3, 4, 1'b1, waited);
        do_pkt(4'b1111, 0, 4, 1'b1, waited);

        // Pointer wraps from 2 past the top back to 0, then 1
        do_pkt(4'b0010, 1, 3, 1'b1, waited);
        do_pkt(4'b0011, 0, 2, 1'b1, waited);
        do_pkt(4'b0011, 1, 1, 1'b1, waited);

        // Valid drops after two flits: error, then the other requester gets the port
        do_pkt(4'b1001, 3, 2, 1'b0, waited);
        do_pkt(4'b1001, 0, 1, 1'b1, waited);

        // Silent owner: timeout pulse 17 cycles after the grant, no count
        wait_grant(4'b0100, 2, got, waited);
        i_req = 4'b0000;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("tmo_c%0d", c), 32'(o_timeout), (c == 17) ? 32'h1 : 32'h0);
            chk("tmo_busy", 32'(o_busy), 32'h1);
        end
        @(negedge clk);
        #1;
        chk("tmo_rel_pulse", 32'(o_timeout), 32'h0);
        chk("tmo_rel_busy",  32'(o_busy), 32'h1);
        @(negedge clk);
        #1;
        chk("tmo_idle_busy", 32'(o_busy), 32'h0);
        chk("tmo_cnt",       32'(o_pkt_cnt), 32'(exp_cnt));

        // No grant while the port is not ready or grants are disabled
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_req        = 4'b0001;
            i_port_ready = (c >= 3);
            i_enable     = (c < 3);
            #1;
            chk("blocked_grant", 32'(o_grant), 32'h0);
            chk("blocked_busy",  32'(o_busy), 32'h0);
        end
        do_pkt(4'b0001, 0, 1, 1'b1, waited);
        chk("ready_latency", 32'(waited), 32'd1);

        // Asynchronous reset in the middle of a packet
        wait_grant(4'b0100, 2, got, waited);
        @(negedge clk);
        lane[2] = 32'h8000_0011;
        @(negedge clk);
        lane[2] = 32'h9000_0012;
        #1;
        chk("pre_rst_flit", o_flit, 32'h8000_0011);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        i_req   = 4'b0000;
        exp_cnt = 0;
        do_pkt(4'b1111, 0, 2, 1'b1, waited);
        @(negedge clk);
        i_req = 4'b0000;
        #1;
        chk("final_busy", 32'(o_busy), 32'h0);
        chk("final_cnt",  32'(o_pkt_cnt), 32'(exp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1);
    end

endmodule
